// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: memory read port toward memory and the instruction
// queue head toward the pipeline.
interface fetch_unit_if;
  logic [15:0] MAB_out;
  logic        mem_rd;
  logic        mem_rdy;
  logic [15:0] MDB_in;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  modport master (
    output MAB_out, mem_rd, ir_out, ir_pc, ir_valid,
    input  mem_rdy, MDB_in, ir_ready
  );

  modport slave (
    input  MAB_out, mem_rd, ir_out, ir_pc, ir_valid,
    output mem_rdy, MDB_in, ir_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction prefetcher: issues sequential 16-bit word reads (one in flight)
// into a small FIFO, and on redirect flushes the queue and drops stale reads.
module fetch_unit #(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  RST_VEC,
  input  logic         redirect,
  input  logic [15:0]  redirect_pc,
  fetch_unit_if.master bus
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state;
  logic [15:0]   fptr;
  logic [15:0]   mab;
  logic          rd;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [15:0]   q_word [QDEPTH];
  logic [15:0]   q_pc   [QDEPTH];
  logic [15:0]   redir_addr;
  logic          push;
  logic          pop;

  assign redir_addr  = redirect_pc & 16'hFFFE;
  assign push        = (state == REQ) && bus.mem_rdy && !redirect && !rst;
  assign pop         = (count != '0) && bus.ir_ready;
  assign count_after = count + CW'(push) - CW'(pop);

  // Redirect outranks everything; a read still in flight at that moment is
  // completed in DROP so its data never lands in the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd    <= 1'b0;
      mab   <= '0;
      fptr  <= RST_VEC & 16'hFFFE;
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (redirect) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      if (state == IDLE || bus.mem_rdy) begin
        state <= REQ;
        rd    <= 1'b1;
        mab   <= redir_addr;
        fptr  <= redir_addr + 16'd2;
      end else begin
        state <= DROP;
        fptr  <= redir_addr;
      end
    end else begin
      count <= count_after;
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case (state)
        IDLE: begin
          if (count < CW'(QDEPTH)) begin
            state <= REQ;
            rd    <= 1'b1;
            mab   <= fptr;
            fptr  <= fptr + 16'd2;
          end
        end
        REQ: begin
          if (bus.mem_rdy) begin
            if (count_after < CW'(QDEPTH)) begin
              mab  <= fptr;
              fptr <= fptr + 16'd2;
            end else begin
              state <= IDLE;
              rd    <= 1'b0;
            end
          end
        end
        DROP: begin
          if (bus.mem_rdy) begin
            state <= REQ;
            mab   <= fptr;
            fptr  <= fptr + 16'd2;
          end
        end
        default: begin
          state <= IDLE;
          rd    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_word[tail] <= bus.MDB_in;
      q_pc[tail]   <= mab;
    end
  end

  // Gating on count keeps stale storage off the outputs after reset or flush.
  assign bus.mem_rd   = rd;
  assign bus.MAB_out  = mab;
  assign bus.ir_valid = (count != '0);
  assign bus.ir_out   = (count != '0) ? q_word[head] : 16'h0000;
  assign bus.ir_pc    = (count != '0) ? q_pc[head]   : 16'h0000;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with hand-computed values, then
// random traffic checked every cycle against a transaction-level model.
module tb_fetch_unit;
  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rst_vec;
  logic        redirect;
  logic [15:0] redirect_pc;
  int          checks = 0;
  int          errors = 0;
  bit          check_en = 1'b0;

  fetch_unit_if bus();

  fetch_unit #(.QDEPTH(QD)) dut (
    .clk         (clk),
    .rst         (rst),
    .RST_VEC     (rst_vec),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Model: queue of {word, pc}, next fetch address, and the single read in
  // flight (address, and whether its data is still wanted).
  logic [31:0] m_q[$];
  bit          m_out  = 1'b0;
  bit          m_keep = 1'b0;
  logic [15:0] m_mab  = 16'h0000;
  logic [15:0] m_fptr = 16'h0000;

  function automatic void issueModel();
    m_out  = 1'b1;
    m_keep = 1'b1;
    m_mab  = m_fptr;
    m_fptr = m_fptr + 16'd2;
  endfunction

  always @(posedge clk) begin : model_update
    int   n;
    bit   pop_m;
    bit   acc;
    logic [15:0] ra;
    if (rst) begin
      m_q.delete();
      m_out  = 1'b0;
      m_keep = 1'b0;
      m_mab  = 16'h0000;
      m_fptr = rst_vec & 16'hFFFE;
    end else if (redirect) begin
      ra = redirect_pc & 16'hFFFE;
      m_q.delete();
      m_fptr = ra;
      if (!m_out || bus.mem_rdy) issueModel();
      else m_keep = 1'b0;
    end else begin
      n     = m_q.size();
      pop_m = (n > 0) && bus.ir_ready;
      acc   = m_out && bus.mem_rdy;
      if (acc && m_keep) m_q.push_back({bus.MDB_in, m_mab});
      if (pop_m) void'(m_q.pop_front());
      if (!m_out) begin
        if (n < QD) issueModel();
      end else if (acc) begin
        if (!m_keep || m_q.size() < QD) issueModel();
        else m_out = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rdy, input logic rr, input logic rd,
                               input logic [15:0] rp, input logic ov, input logic [15:0] ovv);
    @(negedge clk);
    rst         = r;
    bus.mem_rdy = rdy;
    bus.ir_ready = rr;
    redirect    = rd;
    redirect_pc = rp;
    bus.MDB_in  = ov ? ovv : (m_mab ^ 16'hA5A5);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("mem_rd",   16'(bus.mem_rd), 16'(m_out));
      checkOutput("MAB_out",  bus.MAB_out, m_mab);
      checkOutput("ir_valid", 16'(bus.ir_valid), 16'(m_q.size() != 0));
      checkOutput("ir_out",   bus.ir_out, (m_q.size() != 0) ? m_q[0][31:16] : 16'h0000);
      checkOutput("ir_pc",    bus.ir_pc,  (m_q.size() != 0) ? m_q[0][15:0]  : 16'h0000);
    end
  end

  always @(negedge clk) begin
    #2;
    if (check_en) begin
      assert (!(dut.push && int'(dut.count) >= QD)) else begin
        errors++;
        $display("[TB] FAIL push_full: push with count %0d, limit %0d", dut.count, QD);
      end
    end
  end

  initial begin
    rst          = 1'b1;
    rst_vec      = 16'hC000;
    redirect     = 1'b0;
    redirect_pc  = 16'h0000;
    bus.mem_rdy  = 1'b0;
    bus.ir_ready = 1'b0;
    bus.MDB_in   = 16'h0000;
    $display("[TB] start, QDEPTH=%0d", QD);

    applyStimulus(1, 0, 0, 0, 16'h0, 0, 16'h0);
    check_en = 1'b1;
    applyStimulus(1, 1, 1, 0, 16'h0, 0, 16'h0);
    checkOutput("rst_mem_rd",   16'(bus.mem_rd), 16'h0);
    checkOutput("rst_mab",      bus.MAB_out, 16'h0000);
    checkOutput("rst_ir_valid", 16'(bus.ir_valid), 16'h0);
    checkOutput("rst_ir_out",   bus.ir_out, 16'h0000);
    checkOutput("rst_ir_pc",    bus.ir_pc, 16'h0000);

    // Streaming from 0xC000 with zero-wait memory
    applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    checkOutput("first_mem_rd", 16'(bus.mem_rd), 16'h1);
    checkOutput("first_mab",    bus.MAB_out, 16'hC000);
    applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    checkOutput("stream_mab1",   bus.MAB_out, 16'hC002);
    checkOutput("stream_valid1", 16'(bus.ir_valid), 16'h1);
    checkOutput("stream_pc1",    bus.ir_pc, 16'hC000);
    checkOutput("stream_out1",   bus.ir_out, 16'h65A5);
    applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    checkOutput("stream_mab2", bus.MAB_out, 16'hC004);
    checkOutput("stream_pc2",  bus.ir_pc, 16'hC002);
    checkOutput("stream_out2", bus.ir_out, 16'h65A7);
    repeat (6) applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);

    // Redirect while a read waits; its late data must be dropped
    applyStimulus(0, 0, 1, 1, 16'hF00F, 0, 16'h0);
    applyStimulus(0, 1, 1, 0, 16'h0, 1, 16'h1234);
    checkOutput("drop_mem_rd", 16'(bus.mem_rd), 16'h1);
    checkOutput("drop_valid",  16'(bus.ir_valid), 16'h0);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("redir_mab",   bus.MAB_out, 16'hF00E);
    checkOutput("redir_valid", 16'(bus.ir_valid), 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("redir_pc",    bus.ir_pc, 16'hF00E);
    checkOutput("redir_out",   bus.ir_out, 16'h55AB);

    // Redirect with simultaneous pop, then address wrap at 0xFFFE
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 16'h0);
    applyStimulus(0, 1, 1, 1, 16'hFFFE, 0, 16'h0);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("flush_valid", 16'(bus.ir_valid), 16'h0);
    checkOutput("wrap_mab0",   bus.MAB_out, 16'hFFFE);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("wrap_mab1", bus.MAB_out, 16'h0000);
    checkOutput("wrap_pc",   bus.ir_pc, 16'hFFFE);
    checkOutput("wrap_out",  bus.ir_out, 16'h5A5B);

    // Back-pressure: queue fills, fetch idles, one pop frees one fetch
    applyStimulus(0, 1, 0, 1, 16'h1000, 0, 16'h0);
    repeat (QD + 3) applyStimulus(0, 1, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("full_mem_rd", 16'(bus.mem_rd), 16'h0);
    checkOutput("full_valid",  16'(bus.ir_valid), 16'h1);
    checkOutput("full_pc",     bus.ir_pc, 16'h1000);
    checkOutput("full_mab",    bus.MAB_out, 16'(16'h1000 + 2 * (QD - 1)));
    applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("pop_pc",     bus.ir_pc, 16'h1002);
    checkOutput("pop_mem_rd", 16'(bus.mem_rd), 16'h0);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("refill_mem_rd", 16'(bus.mem_rd), 16'h1);
    checkOutput("refill_mab",    bus.MAB_out, 16'(16'h1000 + 2 * QD));

    // Three wait states per read
    repeat (4) begin
      repeat (3) applyStimulus(0, 0, 1, 0, 16'h0, 0, 16'h0);
      applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    end

    // Reset with a read in flight and the queue half full
    applyStimulus(0, 1, 0, 1, 16'h3000, 0, 16'h0);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 16'h0);
    applyStimulus(0, 0, 0, 0, 16'h0, 0, 16'h0);
    rst_vec = 16'h2345;
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 16'h0);
    applyStimulus(1, 1, 0, 0, 16'h0, 0, 16'h0);
    checkOutput("rst2_mem_rd", 16'(bus.mem_rd), 16'h0);
    checkOutput("rst2_mab",    bus.MAB_out, 16'h0000);
    checkOutput("rst2_valid",  16'(bus.ir_valid), 16'h0);
    checkOutput("rst2_ir_out", bus.ir_out, 16'h0000);
    checkOutput("rst2_ir_pc",  bus.ir_pc, 16'h0000);
    applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    checkOutput("rst2_first_rd",  16'(bus.mem_rd), 16'h1);
    checkOutput("rst2_first_mab", bus.MAB_out, 16'h2344);
    applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);
    checkOutput("rst2_pc",    bus.ir_pc, 16'h2344);
    checkOutput("rst2_valid1", 16'(bus.ir_valid), 16'h1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, rdy, rr, rd, ov;
      logic [15:0] rp, ovv;
      r   = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      rr  = ((i / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 11) == 0);
      rp  = 16'($urandom);
      ov  = 1'($urandom_range(0, 1));
      ovv = 16'($urandom);
      if (r) rst_vec = 16'($urandom);
      applyStimulus(r, rdy, rr, rd, rp, ov, ovv);
    end
    repeat (4) applyStimulus(0, 1, 1, 0, 16'h0, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
